// File: rtl/fft4_sequencer.sv
// rtl/fft4_sequencer.sv - 4-point radix-2 DIT FFT sequencer driving one external butterfly.
// Optional FFT4_SCALE_EN: halve every captured butterfly result (1/4 overall scaling).
module fft4_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic [WIDTH-1:0] bf_a,
  output logic [WIDTH-1:0] bf_b,
  output logic [WIDTH-1:0] bf_w,
  input  logic [WIDTH-1:0] bf_apwb,
  input  logic [WIDTH-1:0] bf_anwb
);

  localparam int H = WIDTH / 2;
  // W0 = +1 (max positive real), W1 = -j (most negative symmetric imaginary)
  localparam logic [WIDTH-1:0] W0 = {{H{1'b0}}, 1'b0, {(H-1){1'b1}}};
  localparam logic [WIDTH-1:0] W1 = {1'b1, {(H-2){1'b0}}, 1'b1, {H{1'b0}}};

  typedef enum logic [2:0] {LOAD, BF0, BF1, BF2, BF3, DRAIN} state_t;

  state_t           state;
  logic [1:0]       count;
  logic [WIDTH-1:0] sbuf [4];

  function automatic logic [WIDTH-1:0] scale(input logic [WIDTH-1:0] v);
`ifdef FFT4_SCALE_EN
    return {v[WIDTH-1], v[WIDTH-1:H+1], v[H-1], v[H-1:1]};
`else
    return v;
`endif
  endfunction

  always_comb begin
    bf_a = '0;
    bf_b = '0;
    bf_w = '0;
    case (state)
      BF0: begin bf_a = sbuf[0]; bf_b = sbuf[2]; bf_w = W0; end
      BF1: begin bf_a = sbuf[1]; bf_b = sbuf[3]; bf_w = W0; end
      BF2: begin bf_a = sbuf[0]; bf_b = sbuf[1]; bf_w = W0; end
      BF3: begin bf_a = sbuf[2]; bf_b = sbuf[3]; bf_w = W1; end
      default: ;
    endcase
  end

  // Results sit bit-reversed in place; drain reorders to X0..X3.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      case (count)
        2'd0: out_data = sbuf[0];
        2'd1: out_data = sbuf[2];
        2'd2: out_data = sbuf[1];
        default: out_data = sbuf[3];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      count     <= 2'd0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) sbuf[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            sbuf[count] <= in_data;
            count       <= count + 2'd1;
            if (count == 2'd3) begin
              state    <= BF0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        BF0: begin
          sbuf[0] <= scale(bf_apwb);
          sbuf[2] <= scale(bf_anwb);
          state   <= BF1;
        end
        BF1: begin
          sbuf[1] <= scale(bf_apwb);
          sbuf[3] <= scale(bf_anwb);
          state   <= BF2;
        end
        BF2: begin
          sbuf[0] <= scale(bf_apwb);
          sbuf[1] <= scale(bf_anwb);
          state   <= BF3;
        end
        BF3: begin
          sbuf[2]   <= scale(bf_apwb);
          sbuf[3]   <= scale(bf_anwb);
          state     <= DRAIN;
          out_valid <= 1'b1;
          out_last  <= 1'b0;
        end
        DRAIN: begin
          if (out_valid && out_ready) begin
            count    <= count + 2'd1;
            out_last <= (count == 2'd2);
            if (count == 2'd3) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft4_sequencer.sv
// tb/tb_fft4_sequencer.sv - table-driven, scoreboarded bench for fft4_sequencer.
// Expected bins follow FFT4_SCALE_EN when it is defined for the build.
module tb_fft4_sequencer;
  localparam int WIDTH = 32;
  localparam int H = WIDTH / 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic [WIDTH-1:0] bf_a, bf_b, bf_w, bf_apwb, bf_anwb;

  fft4_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_apwb(bf_apwb), .bf_anwb(bf_anwb)
  );

  always #5 clk = ~clk;

  // Behavioural butterfly: W*B truncated to product bits [WIDTH-2:H-1], sums wrap.
  logic signed [H-1:0] ar, ai, br, bi, wr, wi, tr, ti;
  logic signed [2*H:0] pr, pi;
  always_comb begin
    ar = bf_a[H-1:0]; ai = bf_a[WIDTH-1:H];
    br = bf_b[H-1:0]; bi = bf_b[WIDTH-1:H];
    wr = bf_w[H-1:0]; wi = bf_w[WIDTH-1:H];
    pr = (33'(wr) * 33'(br)) - (33'(wi) * 33'(bi));
    pi = (33'(wr) * 33'(bi)) + (33'(wi) * 33'(br));
    tr = pr[WIDTH-2:H-1];
    ti = pi[WIDTH-2:H-1];
    bf_apwb = {ai + ti, ar + tr};
    bf_anwb = {ai - ti, ar - tr};
  end

  typedef struct {
    logic [3:0][WIDTH-1:0] x;
    logic [3:0][WIDTH-1:0] y;
    bit                    gap;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  vec_t vecs [5];
  exp_t exp_q [$];
  int   tests = 0;
  int   fails = 0;

  function automatic logic [WIDTH-1:0] cpx(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {i[H-1:0], r[H-1:0]};
  endfunction

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns #1 after the edge that accepts the 4th sample (first BF0 cycle).
  task automatic send_frame(input logic [3:0][WIDTH-1:0] x, input logic [3:0][WIDTH-1:0] y,
                            input bit gap, input bit push);
    int n;
    if (push)
      for (int i = 0; i < 4; i++) exp_q.push_back('{data: y[i], last: (i == 3)});
    for (int i = 0; i < 4; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_data  = x[i];
      n = 0;
      while (!in_ready && n < 100) begin
        tick();
        n++;
      end
      if (!in_ready) begin
        tests++; fails++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      tick();
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor, sampled on the falling edge away from state updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_ready || out_valid) begin
        tests++;
        if ((bf_a | bf_b | bf_w) !== '0) begin
          fails++;
          $display("FAIL bf_idle_zero: got a=%h b=%h w=%h expected 0", bf_a, bf_b, bf_w);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_bin: got %h expected none", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            fails++;
            $display("FAIL bin: got %h last=%b expected %h last=%b", out_data, out_last, e.data, e.last);
          end
        end
      end
    end
  end

  initial begin
    vecs[0].x = {cpx(0, 0), cpx(0, 0), cpx(0, 0), cpx(1000, 0)};
    vecs[1].x = {cpx(1000, 0), cpx(1000, 0), cpx(1000, 0), cpx(1000, 0)};
    vecs[2].x = {cpx(0, 0), cpx(0, 0), cpx(1000, 0), cpx(0, 0)};
`ifdef FFT4_SCALE_EN
    vecs[0].y = {cpx(250, 0), cpx(250, 0), cpx(250, 0), cpx(250, 0)};
    vecs[1].y = {cpx(0, 0), cpx(0, 0), cpx(0, 0), cpx(998, 0)};
    vecs[2].y = {cpx(0, 250), cpx(-250, 0), cpx(0, -250), cpx(249, 0)};
`else
    vecs[0].y = {cpx(1000, 0), cpx(1000, 0), cpx(1000, 0), cpx(1000, 0)};
    vecs[1].y = {cpx(1, 1), cpx(1, 0), cpx(1, -1), cpx(3997, 0)};
    vecs[2].y = {cpx(0, 1000), cpx(-999, 0), cpx(0, -1000), cpx(999, 0)};
`endif
    vecs[0].gap = 1'b0;
    vecs[1].gap = 1'b0;
    vecs[2].gap = 1'b0;
    vecs[3] = vecs[0];
    vecs[3].gap = 1'b1;
    vecs[4] = vecs[1];
    vecs[4].gap = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", out_data, '0);
    check("rst_bf", bf_a | bf_b | bf_w, '0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int v = 0; v < 5; v++) begin
      send_frame(vecs[v].x, vecs[v].y, vecs[v].gap, 1'b1);
      check("bf0_busy", 32'(busy), 32'd1);
      check("bf0_in_ready", 32'(in_ready), 32'd0);
      repeat (3) tick();
      check("bf3_out_valid", 32'(out_valid), 32'd0);
      tick();
      check("k4_out_valid", 32'(out_valid), 32'd1);
      repeat (3) tick();
      check("k7_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("k8_in_ready", 32'(in_ready), 32'd1);
      check("k8_out_valid", 32'(out_valid), 32'd0);
      wait_empty();
    end

    // Backpressure: hold each bin for 5 cycles.
    out_ready = 1'b0;
    send_frame(vecs[1].x, vecs[1].y, 1'b0, 1'b1);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        tick();
        n++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      repeat (5) begin
        tick();
        check("bp_data", out_data, vecs[1].y[b]);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("bp_done_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    wait_empty();

    // Reset during BF2, then a fresh frame.
    send_frame(vecs[1].x, vecs[1].y, 1'b0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_bf", bf_a | bf_b | bf_w, '0);
    rst = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    send_frame(vecs[0].x, vecs[0].y, 1'b0, 1'b1);
    repeat (12) tick();
    wait_empty();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft4_sequencer.md
# fft4_sequencer

Controller that computes a 4-point radix-2 DIT FFT by time-sharing one external combinational butterfly unit over four compute cycles. Complex samples stream in one per handshake, the block drives the butterfly's A/B/W operands and captures its two results in place, then streams the four bins out in natural order. It sits between the sample source and any downstream FFT consumer, owning all butterfly sequencing and twiddle selection.

## Interface
- WIDTH, 32: packed complex width; imaginary part in [WIDTH-1:WIDTH/2], real part in [WIDTH/2-1:0], both signed Q1.(WIDTH/2-1).
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_data  in  WIDTH  packed complex input sample.
- out_valid  out  1  output bin valid.
- out_ready  in  1  consumer accepts the bin.
- out_data  out  WIDTH  packed complex FFT bin.
- out_last  out  1  high with the 4th bin (X3).
- busy  out  1  high in any state other than LOAD.
- bf_a, bf_b, bf_w  out  WIDTH each  butterfly operands.
- bf_apwb, bf_anwb  in  WIDTH each  butterfly results A+W·B and A−W·B, combinational from bf_*, same packing.

## Operation
- States: LOAD, BF0, BF1, BF2, BF3, DRAIN. Buffer buf[0..3] of WIDTH bits; 2-bit count shared by LOAD and DRAIN.
- LOAD: in_ready=1. On in_valid&&in_ready, buf[count]<=in_data, count++. Handshake at count==3 -> BF0, count<=0.
- Twiddles: W0={16'h0000,16'h7FFF} (≈1), W1={16'h8001,16'h0000} (≈−j), for WIDTH=32; scales with WIDTH/2 in general.
- BF0: a=buf[0], b=buf[2], w=W0; buf[0]<=apwb, buf[2]<=anwb.
- BF1: a=buf[1], b=buf[3], w=W0; buf[1]<=apwb, buf[3]<=anwb.
- BF2: a=buf[0], b=buf[1], w=W0; buf[0]<=apwb (X0), buf[1]<=anwb (X2).
- BF3: a=buf[2], b=buf[3], w=W1; buf[2]<=apwb (X1), buf[3]<=anwb (X3).
- Each BFn lasts exactly one cycle; BF3 -> DRAIN.
- DRAIN: out_valid=1, out_data = buf[0], buf[2], buf[1], buf[3] for count 0..3 (X0..X3); out_last=1 at count 3. Advance only on out_valid&&out_ready; out_data held stable while stalled. Handshake at count 3 -> LOAD, count<=0.
- bf_a/bf_b/bf_w = 0 outside BF0–BF3. Captured results are not saturated; wrap is the butterfly's behaviour.
- No overlap: input is refused (in_ready=0) from BF0 until DRAIN completes.

## Timing
- Reset: state LOAD, count 0, in_ready=1 the cycle after rst deasserts (in_ready=0 while rst high), out_valid=0, out_last=0, busy=0, out_data=0, bf_*=0, buf cleared to 0.
- rst asserted in any state, including mid-compute or mid-drain: partial frame discarded, reset values at next edge.
- 4th input accepted at edge k: BF0..BF3 occupy cycles k..k+3, out_valid first high after edge k+4. With out_ready held high, X3 handshakes at edge k+8 and in_ready is high after it.
- Throughput with no stalls: one frame per 12 cycles.
- Input stalls (in_valid=0) in LOAD hold count; output stalls hold DRAIN indefinitely.

## Configuration
- FFT4_SCALE_EN defined: each captured result half (re and im independently) is arithmetic-shifted right by 1 (floor) before writing to buf, giving total 1/4 scaling and no stage-2 overflow for full-scale input.
- Undefined: results written unmodified; outputs may wrap for inputs above quarter-scale.

## Test plan
Bench uses a behavioural butterfly model honouring the bf_* contract (product bits [WIDTH-2:WIDTH/2-1] truncation).
- Impulse: inputs re=1000,0,0,0 (im 0) -> X0..X3 all re=1000, im=0; out_last only on 4th; out_valid first after edge k+4.
- DC: four inputs re=1000 -> X0 re=3997, X1 {re=1,im=−1}, X2 re=1, X3 {re=1,im=+1}.
- FFT4_SCALE_EN, impulse re=1000 -> all four bins re=250, im=0.
- Backpressure: out_ready low for 5 cycles at each bin -> out_data stable, no bin lost or duplicated, in_ready stays 0 until X3 handshake.
- Reset in BF2 then new impulse frame -> no stale output, new frame's outputs correct, busy low right after reset.
- Gapped input (in_valid toggling every other cycle) -> same result as back-to-back, bf_* zero in LOAD/DRAIN.
